// File: rtl/data_mem_if.sv
// Request/response bus between a requester and data_mem_ctrl.
interface data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-serial little-endian data memory with byte/half/word loads and stores.
// Optional macro DATA_MEM_ALIGN_CHECK_EN rejects misaligned accesses.
//
// state | meaning
// IDLE  | ready for a request
// XFER  | one byte moved per cycle through the single byte port
// RESP  | one-cycle response strobe
module data_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t state, state_nx;

  logic [7:0]        mem [DEPTH];
  logic              wr_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       acc_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              size_ok;
  logic              misaligned;
  logic              req_bad;
  logic [7:0]        rd_byte;
  logic [31:0]       acc_full;
  logic [31:0]       ext;
  logic              unused_bits;

  assign bus.req_ready = reset && (state == IDLE);
  assign bus.rsp_valid = reset && (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = reset && (state != IDLE);

  assign accept  = bus.req_valid && bus.req_ready;
  assign size_ok = (bus.req_size != 2'd3) && !((bus.req_size == 2'd2) && (DATA_W == 16));

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_bad = !size_ok || misaligned;

  assign rd_byte  = mem[addr_q];
  // The byte read in the final XFER cycle is merged here so the response
  // can be registered at the same edge without an extra cycle.
  assign acc_full = acc_q | (32'(rd_byte) << {idx_q, 3'b000});

  always_comb begin
    ext = acc_full;
    case (size_q)
      2'd0:    ext = {{24{sgn_q & acc_full[7]}}, acc_full[7:0]};
      2'd1:    ext = {{16{sgn_q & acc_full[15]}}, acc_full[15:0]};
      default: ext = acc_full;
    endcase
  end

  assign unused_bits = ^{bus.req_addr, ext};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = req_bad ? RESP : XFER;
      XFER:    if (idx_q == last_q) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= 2'd0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_write;
        sgn_q   <= bus.req_signed;
        size_q  <= bus.req_size;
        idx_q   <= 2'd0;
        last_q  <= {bus.req_size[1], bus.req_size[1] | bus.req_size[0]};
        addr_q  <= bus.req_addr[AW-1:0];
        wdata_q <= 32'(bus.req_wdata);
        acc_q   <= '0;
        if (req_bad) begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end
      end
      if (state == XFER) begin
        if (wr_q) mem[addr_q] <= wdata_q[{idx_q, 3'b000} +: 8];
        acc_q  <= acc_full;
        addr_q <= addr_q + 1'b1;
        idx_q  <= idx_q + 2'd1;
        if (idx_q == last_q) begin
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= wr_q ? '0 : ext[DATA_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench: one 16-bit and one 32-bit controller instance.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy16, busy32;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_mem_if #(.DATA_W(16), .ADDR_W(16)) b16 ();
  data_mem_if #(.DATA_W(32), .ADDR_W(16)) b32 ();

  data_mem_ctrl #(.DATA_W(16), .DEPTH(64), .ADDR_W(16)) dut16 (
    .clk(clk), .reset(reset), .bus(b16), .busy(busy16));
  data_mem_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(16)) dut32 (
    .clk(clk), .reset(reset), .bus(b32), .busy(busy32));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w32, input logic v, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [15:0] ad, input logic [31:0] wd);
    if (w32) begin
      b32.req_valid = v; b32.req_write = wr; b32.req_size = sz;
      b32.req_signed = sg; b32.req_addr = ad; b32.req_wdata = wd;
    end else begin
      b16.req_valid = v; b16.req_write = wr; b16.req_size = sz;
      b16.req_signed = sg; b16.req_addr = ad; b16.req_wdata = wd[15:0];
    end
  endtask

  // lat = cycles from the accept edge to the response strobe (0 = no response)
  task automatic do_req(input bit w32, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [15:0] ad, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    drive(w32, 1'b1, wr, sz, sg, ad, wd);
    @(posedge clk); #1;
    drive(w32, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (w32 ? b32.rsp_valid : b16.rsp_valid) begin
        lat = i;
        rd  = w32 ? b32.rsp_rdata : 32'(b16.rsp_rdata);
        er  = w32 ? b32.rsp_err : b16.rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic er;
  int lat;
  int nz;
  bit seen;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(b16.req_ready), 32'd0);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_rspv", 32'(b16.rsp_valid), 32'd0);
    chk("rst_rdata", 32'(b16.rsp_rdata), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(b16.req_ready), 32'd1);

    // half store / load, 16-bit
    do_req(1'b0, 1'b1, 2'd1, 1'b0, 16'h0010, 32'h0000BEEF, rd, er, lat);
    chk("sth_lat", 32'(lat), 32'd3);
    chk("sth_rd", rd, 32'h0);
    chk("sth_err", 32'(er), 32'd0);
    chk("sth_m10", 32'(dut16.mem[16]), 32'hEF);
    chk("sth_m11", 32'(dut16.mem[17]), 32'hBE);
    do_req(1'b0, 1'b0, 2'd1, 1'b0, 16'h0010, 32'h0, rd, er, lat);
    chk("ldh_lat", 32'(lat), 32'd3);
    chk("ldh_rd", rd, 32'h0000BEEF);

    // byte store, signed / unsigned loads, upper address bits ignored
    do_req(1'b0, 1'b1, 2'd0, 1'b0, 16'h0005, 32'h00000080, rd, er, lat);
    chk("stb_lat", 32'(lat), 32'd2);
    do_req(1'b0, 1'b0, 2'd0, 1'b1, 16'h0005, 32'h0, rd, er, lat);
    chk("ldbs_rd", rd, 32'h0000FF80);
    do_req(1'b0, 1'b0, 2'd0, 1'b0, 16'h4005, 32'h0, rd, er, lat);
    chk("ldbu_rd", rd, 32'h00000080);
    chk("hold_rd", 32'(b16.rsp_rdata), 32'h0080);
    chk("hold_v", 32'(b16.rsp_valid), 32'd0);

    // illegal size on 16-bit: word
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 16'h0010, 32'h00001234, rd, er, lat);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_err", 32'(er), 32'd1);
    chk("ill_rd", rd, 32'h0);
    chk("ill_m10", 32'(dut16.mem[16]), 32'hEF);
    chk("ill_m12", 32'(dut16.mem[18]), 32'h00);
    do_req(1'b1, 1'b0, 2'd3, 1'b0, 16'h0000, 32'h0, rd, er, lat);
    chk("ill3_err", 32'(er), 32'd1);
    chk("ill3_lat", 32'(lat), 32'd1);

    // request after an error response clears err
    do_req(1'b0, 1'b0, 2'd0, 1'b0, 16'h0011, 32'h0, rd, er, lat);
    chk("ok_err", 32'(er), 32'd0);
    chk("ok_rd", rd, 32'h00BE);

    // misaligned half load at 0x11: bytes BE,00
    do_req(1'b0, 1'b0, 2'd1, 1'b0, 16'h0011, 32'h0, rd, er, lat);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_lat", 32'(lat), 32'd1);
`else
    chk("mis_err", 32'(er), 32'd0);
    chk("mis_rd", rd, 32'h00BE);
`endif

    // req_valid held through XFER: no second accept until IDLE
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0030, 32'h00001234);
    @(posedge clk); #1;
    chk("hv_rdy1", 32'(b16.req_ready), 32'd0);
    chk("hv_busy1", 32'(busy16), 32'd1);
    @(posedge clk); #1;
    chk("hv_rdy2", 32'(b16.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("hv_rspv", 32'(b16.rsp_valid), 32'd1);
    @(posedge clk); #1;
    chk("hv_rdy4", 32'(b16.req_ready), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
    @(posedge clk); #1;
    chk("hv_idle", 32'(busy16), 32'd0);
    chk("hv_m30", 32'(dut16.mem[48]), 32'h34);
    chk("hv_m31", 32'(dut16.mem[49]), 32'h12);

    // 32-bit: wrapping word store at 0x3E
    do_req(1'b1, 1'b1, 2'd2, 1'b0, 16'h003E, 32'h11223344, rd, er, lat);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    chk("w_lat", 32'(lat), 32'd1);
    chk("w_err", 32'(er), 32'd1);
    chk("w_m3e", 32'(dut32.mem[62]), 32'h00);
    chk("w_m00", 32'(dut32.mem[0]), 32'h00);
`else
    chk("w_lat", 32'(lat), 32'd5);
    chk("w_err", 32'(er), 32'd0);
    chk("w_m3e", 32'(dut32.mem[62]), 32'h44);
    chk("w_m3f", 32'(dut32.mem[63]), 32'h33);
    chk("w_m00", 32'(dut32.mem[0]), 32'h22);
    chk("w_m01", 32'(dut32.mem[1]), 32'h11);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 16'h003E, 32'h0, rd, er, lat);
    chk("lw_rd", rd, 32'h11223344);
    chk("lw_lat", 32'(lat), 32'd5);
`endif

    // 32-bit half signed/unsigned and byte sign extension
    do_req(1'b1, 1'b1, 2'd1, 1'b0, 16'h0020, 32'h00008001, rd, er, lat);
    do_req(1'b1, 1'b0, 2'd1, 1'b1, 16'h0020, 32'h0, rd, er, lat);
    chk("lhs32_rd", rd, 32'hFFFF8001);
    do_req(1'b1, 1'b0, 2'd1, 1'b0, 16'h0020, 32'h0, rd, er, lat);
    chk("lhu32_rd", rd, 32'h00008001);
    do_req(1'b1, 1'b0, 2'd0, 1'b1, 16'h0021, 32'h0, rd, er, lat);
    chk("lbs32_rd", rd, 32'hFFFFFF80);

    // reset during XFER of a word store
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0008, 32'hA5A5A5A5);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (b32.rsp_valid) seen = 1'b1;
    end
    chk("mr_ready", 32'(b32.req_ready), 32'd0);
    chk("mr_busy", 32'(busy32), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_rel_rdy", 32'(b32.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (b32.rsp_valid) seen = 1'b1;
    end
    chk("mr_no_rsp", 32'(seen), 32'd0);
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      if (dut32.mem[i] !== 8'h00) nz++;
      if (dut16.mem[i] !== 8'h00) nz++;
    end
    chk("mr_mem_zero", 32'(nz), 32'd0);
    do_req(1'b1, 1'b0, 2'd0, 1'b0, 16'h0008, 32'h0, rd, er, lat);
    chk("mr_ld", rd, 32'h0);
    chk("mr_ld_lat", 32'(lat), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, bus width in bits; SHALL be 16 or 32.
REQ-002 Parameter DEPTH, default 64, memory size in bytes; SHALL be a power of two, at least 4.
REQ-003 Parameter ADDR_W, default 16, request address width.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  0 = byte, 1 = half (2 bytes), 2 = word (4 bytes), 3 = illegal.
REQ-010 req_signed  input  1  load result is sign-extended when 1, zero-extended when 0.
REQ-011 req_addr  input  ADDR_W  byte address.
REQ-012 req_wdata  input  DATA_W  store data; low bytes used.
REQ-013 rsp_valid  output  1  one-cycle response strobe.
REQ-014 rsp_rdata  output  DATA_W  load result.
REQ-015 rsp_err  output  1  request rejected; qualified by rsp_valid.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, XFER and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both high, and all req_* fields are latched in that cycle.
REQ-019 req_valid outside IDLE SHALL be ignored, with no effect on state or memory.
REQ-020 Storage SHALL be DEPTH bytes, little-endian, using a single byte port: XFER moves exactly one byte per cycle, byte k at (addr + k) mod DEPTH.
REQ-021 Effective address SHALL be req_addr[log2(DEPTH)-1:0]; upper bits are ignored; multi-byte accesses wrap from DEPTH-1 to 0.
REQ-022 For an n-byte legal access accepted at cycle T, bytes SHALL transfer in cycles T+1..T+n, with rsp_valid high for exactly one cycle at T+n+1, then IDLE.
REQ-023 A store SHALL write byte k = req_wdata[8k+7:8k]; rsp_rdata SHALL be 0 for stores.
REQ-024 A load SHALL assemble n bytes and extend to DATA_W per req_signed, using bit 8n-1 as the sign; a word load with DATA_W=32 is unextended.
REQ-025 Illegal size (3, or 2 when DATA_W=16) SHALL skip XFER, leave memory unchanged, and assert rsp_valid=1, rsp_err=1, rsp_rdata=0 at T+1.
REQ-026 rsp_rdata and rsp_err SHALL hold their values until the next response; rsp_valid is 0 outside RESP.
REQ-027 A load from a location written by an immediately preceding store SHALL return the new data, with no hazard window.

Reset
REQ-028 While reset=0 at a rising edge: state SHALL go to IDLE; req_ready=0 and busy=0 during reset; rsp_valid, rsp_err and rsp_rdata SHALL be 0; all memory bytes SHALL be 0.
REQ-029 Reset asserted mid-XFER SHALL abort the access with no response; bytes already written stay written until cleared by the same reset.
REQ-030 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 With macro DATA_MEM_ALIGN_CHECK_EN defined: a legal-size access whose effective address is not a multiple of n SHALL be rejected as in REQ-025 (error at T+1, no memory change).
REQ-032 Without DATA_MEM_ALIGN_CHECK_EN: misaligned accesses SHALL execute byte-wise per REQ-020/021; rsp_err is raised only for illegal size.

Verification
REQ-033 DATA_W=16, DEPTH=64: store half 0xBEEF at addr 0x10, then load half unsigned -> rsp_rdata=0xBEEF; mem[0x10]=0xEF, mem[0x11]=0xBE; response 3 cycles after accept.
REQ-034 Store byte 0x80 at addr 5; load byte signed -> rsp_rdata=0xFF80; load byte unsigned -> 0x0080.
REQ-035 DATA_W=32, DEPTH=64: store word 0x11223344 at addr 0x3E with the macro undefined -> mem[0x3E]=0x44, mem[0x3F]=0x33, mem[0x00]=0x22, mem[0x01]=0x11; with the macro defined -> rsp_err=1 at T+1 and memory unchanged.
REQ-036 DATA_W=16: req_size=2 -> rsp_valid=1, rsp_err=1, rsp_rdata=0 at T+1, memory unchanged; req_valid held high during XFER -> no second accept until IDLE.
REQ-037 Assert reset=0 at cycle T+1 of a word store -> no rsp_valid; after release, every byte reads 0 and req_ready=1.
